// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: holds operands on the divider, waits out its settle time, then writes HI/LO
module div_hilo_ctrl #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] div_m,
   output logic [31:0] div_q,
   input  logic [63:0] div_z,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        dbz,
   input  logic        dbz_clr
);
   typedef enum logic [1:0] {IDLE, SETTLE, ZERO} state_t;
   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_m, r_q, r_dvd, r_hi, r_lo;
   logic        r_done, r_dbz;
   logic        w_accept, w_ld_div, w_ld_zero;
   assign busy        = r_state != IDLE;
   assign start_ready = !busy;
   assign w_accept    = start_valid && start_ready;
   assign div_m       = r_m;
   assign div_q       = r_q;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign done        = r_done;
   assign dbz         = r_dbz;
   // next state, settle countdown and the two completion strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ld_div    = 1'b0;
      w_ld_zero   = 1'b0;
      case (r_state)
         IDLE: if (w_accept) begin
            w_state_nxt = (divisor != 32'd0) ? SETTLE : ZERO;
            w_cnt_nxt   = (divisor != 32'd0) ? 4'(SETTLE_CYCLES - 1) : r_cnt;
         end
         SETTLE: begin
            w_ld_div    = r_cnt == 4'd0;
            w_state_nxt = w_ld_div ? IDLE : SETTLE;
            w_cnt_nxt   = w_ld_div ? r_cnt : r_cnt - 4'd1;
         end
         ZERO: begin
            w_ld_zero   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   // state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // operand latch; a zero divisor never reaches the divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m   <= 32'd0;
         r_q   <= 32'd0;
         r_dvd <= 32'd0;
      end else if (w_accept) begin
         r_dvd <= dividend;
         if (divisor != 32'd0) begin
            r_m <= dividend;
            r_q <= divisor;
         end
      end
   end
   // HI/LO writeback: operation results take priority over direct writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_ld_div) begin
         r_hi <= div_z[63:32];
         r_lo <= div_z[31:0];
      end else if (w_ld_zero) begin
         r_hi <= r_dvd;
         r_lo <= 32'hFFFF_FFFF;
      end else begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end
   // completion pulse and sticky divide-by-zero flag (set beats clear)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
      end else begin
         r_done <= w_ld_div || w_ld_zero;
         r_dbz  <= w_ld_zero ? 1'b1 : (dbz_clr ? 1'b0 : r_dbz);
      end
   end
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: vector table plus corner sequences against a behavioural divider
module tb_div_hilo_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [31:0] dividend = '0, divisor = '0;
   logic [31:0] div_m, div_q;
   logic [63:0] div_z;
   logic        hi_we = 1'b0, lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi, lo;
   logic        busy, done, dbz;
   logic        dbz_clr = 1'b0;
   int          n_total = 0, n_pass = 0;

   typedef struct {logic [31:0] a, b, eh, el; logic ed; int lat;} vec_t;
   typedef struct {logic [31:0] eh, el; logic ed;} exp_t;
   vec_t tbl[7];
   exp_t sb[$];

   div_hilo_ctrl #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .dividend(dividend), .divisor(divisor), .div_m(div_m), .div_q(div_q), .div_z(div_z),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .dbz(dbz), .dbz_clr(dbz_clr)
   );

   always #5 clk = ~clk;

   // behavioural divider: remainder in the top half, quotient in the bottom
   always_comb div_z = (div_q == 32'd0) ? 64'd0 : {div_m % div_q, div_m / div_q};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input vec_t v);
      int n;
      logic [31:0] m0, q0;
      logic stable;
      exp_t e;
      start_valid = 1'b1;
      dividend = v.a;
      divisor = v.b;
      n = 0;
      while (!start_ready && n < 50) begin tick(); n++; end
      tick();
      start_valid = 1'b0;
      sb.push_back('{v.eh, v.el, v.ed});
      m0 = div_m;
      q0 = div_q;
      if (v.b != 32'd0) begin
         chk("div_m_load", m0, v.a);
         chk("div_q_load", q0, v.b);
      end
      stable = 1'b1;
      n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
         if (div_m !== m0 || div_q !== q0) stable = 1'b0;
      end
      chk("latency", 32'(n), 32'(v.lat));
      e = sb.pop_front();
      chk("hi", hi, e.eh);
      chk("lo", lo, e.el);
      chk("dbz", 32'(dbz), 32'(e.ed));
      chk("operands_stable", 32'(stable), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      tick();
      chk("done_single", 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      logic ok;
      tbl[0] = '{32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 4};
      tbl[1] = '{32'd2, 32'd1, 32'd0, 32'd2, 1'b0, 4};
      tbl[2] = '{32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 4};
      tbl[3] = '{32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 4};
      tbl[4] = '{32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1};
      tbl[5] = '{32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 4};
      tbl[6] = '{32'd5, 32'd10, 32'd5, 32'd0, 1'b1, 4};

      repeat (3) tick();
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(dbz), 32'd0);
      chk("rst_div_m", div_m, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", 32'(start_ready), 32'd1);

      for (int i = 0; i < 7; i++) do_op(tbl[i]);

      // direct LO write colliding with a capture edge
      start_valid = 1'b1; dividend = 32'd9; divisor = 32'd4;
      tick();
      start_valid = 1'b0;
      repeat (3) tick();
      lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      tick();
      lo_we = 1'b0;
      chk("coll_done", 32'(done), 32'd1);
      chk("coll_lo", lo, 32'd2);
      chk("coll_hi", hi, 32'd1);
      tick();
      lo_we = 1'b1;
      tick();
      lo_we = 1'b0;
      chk("idle_lo_we", lo, 32'hDEAD_BEEF);
      chk("idle_lo_we_hi", hi, 32'd1);
      chk("idle_we_no_done", 32'(done), 32'd0);
      hi_we = 1'b1; wdata = 32'h1234_5678;
      tick();
      hi_we = 1'b0;
      chk("idle_hi_we", hi, 32'h1234_5678);

      // divide by zero, clear, and set-beats-clear
      dbz_clr = 1'b1;
      tick();
      dbz_clr = 1'b0;
      chk("dbz_cleared", 32'(dbz), 32'd0);
      start_valid = 1'b1; dividend = 32'd7; divisor = 32'd0;
      tick();
      start_valid = 1'b0;
      chk("zero_busy", 32'(busy), 32'd1);
      chk("zero_div_m", div_m, 32'd9);
      chk("zero_div_q", div_q, 32'd4);
      tick();
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_hi", hi, 32'd7);
      chk("zero_lo", lo, 32'hFFFF_FFFF);
      chk("zero_dbz", 32'(dbz), 32'd1);
      tick();
      start_valid = 1'b1; dividend = 32'd5;
      tick();
      start_valid = 1'b0;
      dbz_clr = 1'b1;
      tick();
      dbz_clr = 1'b0;
      chk("dbz_set_wins", 32'(dbz), 32'd1);
      chk("zero2_hi", hi, 32'd5);
      chk("zero2_done", 32'(done), 32'd1);
      tick();

      // back-to-back with a request held during SETTLE
      start_valid = 1'b1; dividend = 32'd2; divisor = 32'd1;
      tick();
      chk("b2b_busy", 32'(busy), 32'd1);
      dividend = 32'd4; divisor = 32'd2;
      ok = 1'b1;
      n = 0;
      while (!done && n < 20) begin
         if (start_ready !== 1'b0 || div_m !== 32'd2 || div_q !== 32'd1) ok = 1'b0;
         tick();
         n++;
      end
      chk("b2b_lat1", 32'(n), 32'd4);
      chk("busy_blocks", 32'(ok), 32'd1);
      chk("b2b_lo1", lo, 32'd2);
      chk("b2b_hi1", hi, 32'd0);
      chk("b2b_ready_at_done", 32'(start_ready), 32'd1);
      tick();
      start_valid = 1'b0;
      chk("b2b_accept2", 32'(busy), 32'd1);
      chk("b2b_done_drop", 32'(done), 32'd0);
      chk("b2b_div_m2", div_m, 32'd4);
      chk("b2b_div_q2", div_q, 32'd2);
      n = 0;
      while (!done && n < 20) begin tick(); n++; end
      chk("b2b_lat2", 32'(n), 32'd4);
      chk("b2b_lo2", lo, 32'd2);
      chk("b2b_hi2", hi, 32'd0);
      tick();

      // asynchronous reset in the middle of SETTLE
      start_valid = 1'b1; dividend = 32'd9; divisor = 32'd4;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      chk("arst_dbz", 32'(dbz), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) ok = 1'b1;
      end
      chk("arst_no_done", 32'(ok), 32'd0);
      chk("arst_ready", 32'(start_ready), 32'd1);
      chk("arst_lo_kept", lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
